// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD command/ASCII constants, FSM state types and small helpers
package lcd_pkg;
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_DASH   = 8'h2D;
    typedef enum logic [2:0] {PWR_WAIT, INIT, SNAP, ADDR, CHARS, GAP} lcd_state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD} xfer_phase_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ? b : ASCII_DASH;
    endfunction
endpackage

// File: rtl/lcd_clock_writer_byte_xfer.sv
// lcd_byte_xfer: one LCD bus write as SETUP / E PULSE / HOLD with back-to-back restart
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CLKS      = 2,
    parameter int E_CLKS          = 12,
    parameter int WAIT_CLKS       = 2500,
    parameter int CLEAR_WAIT_CLKS = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    localparam int CW = $clog2(max2(max2(SETUP_CLKS, E_CLKS), max2(WAIT_CLKS, CLEAR_WAIT_CLKS))) + 1;

    xfer_phase_t   phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          long_q;
    logic          wrap;

    // terminal count of the current phase
    always_comb begin
        last = phase == PH_SETUP ? CW'(SETUP_CLKS - 1) :
               phase == PH_PULSE ? CW'(E_CLKS - 1) :
               long_q            ? CW'(CLEAR_WAIT_CLKS - 1) : CW'(WAIT_CLKS - 1);
        wrap = cnt == last;
    end

    assign busy  = phase != PH_IDLE;
    assign done  = phase == PH_HOLD && wrap;
    assign lcd_e = phase == PH_PULSE;

    // phase sequencing; a start on the last hold cycle chains the next byte with no idle gap
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else if (start && (!busy || done)) begin
            phase    <= PH_SETUP;
            cnt      <= '0;
            long_q   <= long_wait;
            lcd_rs   <= rs;
            lcd_data <= data;
        end else if (busy && wrap) begin
            phase <= phase == PH_SETUP ? PH_PULSE : phase == PH_PULSE ? PH_HOLD : PH_IDLE;
            cnt   <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_clock_writer.sv
// lcd_clock_writer: HD44780 init then continuous "HH:MM:SS.cc" refresh of line 1
module lcd_clock_writer
    import lcd_pkg::*;
#(
    parameter int POWERON_CLKS    = 750000,
    parameter int SETUP_CLKS      = 2,
    parameter int E_CLKS          = 12,
    parameter int WAIT_CLKS       = 2500,
    parameter int CLEAR_WAIT_CLKS = 100000,
    parameter int GAP_CLKS        = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hour_10,
    input  logic [7:0] hour_1,
    input  logic [7:0] min_10,
    input  logic [7:0] min_1,
    input  logic [7:0] sec_10,
    input  logic [7:0] sec_1,
    input  logic [7:0] cnt_10,
    input  logic [7:0] cnt_1,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);
    localparam int CW = $clog2(max2(max2(max2(POWERON_CLKS, GAP_CLKS), max2(SETUP_CLKS, E_CLKS)),
                                    max2(WAIT_CLKS, CLEAR_WAIT_CLKS))) + 1;
    localparam logic [3:0][7:0] INIT_CMDS = {CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON, CMD_FUNC_SET};

    lcd_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [3:0]       idx, idx_nx, nidx;
    logic             init_nx, frame_nx;
    logic [7:0][7:0]  snap;
    logic [10:0][7:0] line;
    logic             x_start, x_rs, x_long, x_busy, x_done;
    logic [7:0]       x_data;

    assign lcd_rw = 1'b0;
    assign nidx   = idx + 4'd1;
    assign x_long = !x_rs && x_data == CMD_CLEAR;
    assign line   = {sanitize(snap[7]), sanitize(snap[6]), ASCII_DOT,
                     sanitize(snap[5]), sanitize(snap[4]), ASCII_COLON,
                     sanitize(snap[3]), sanitize(snap[2]), ASCII_COLON,
                     sanitize(snap[1]), sanitize(snap[0])};

    lcd_byte_xfer #(
        .SETUP_CLKS      (SETUP_CLKS),
        .E_CLKS          (E_CLKS),
        .WAIT_CLKS       (WAIT_CLKS),
        .CLEAR_WAIT_CLKS (CLEAR_WAIT_CLKS)
    ) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .start     (x_start),
        .rs        (x_rs),
        .data      (x_data),
        .long_wait (x_long),
        .busy      (x_busy),
        .done      (x_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data)
    );

    // next-state logic; each byte is launched in the cycle the previous one finishes
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        init_nx  = init_done;
        frame_nx = 1'b0;
        x_start  = 1'b0;
        x_rs     = 1'b0;
        x_data   = '0;
        case (state)
            PWR_WAIT: if (cnt == CW'(POWERON_CLKS - 1)) begin
                state_nx = INIT;
                idx_nx   = '0;
                x_start  = 1'b1;
                x_data   = INIT_CMDS[0];
            end else cnt_nx = cnt + 1'b1;
            INIT: if (x_done) begin
                if (idx == 4'd3) begin
                    state_nx = SNAP;
                    init_nx  = 1'b1;
                end else begin
                    idx_nx  = nidx;
                    x_start = 1'b1;
                    x_data  = INIT_CMDS[nidx[1:0]];
                end
            end
            SNAP: if (!x_busy) begin
                state_nx = ADDR;
                x_start  = 1'b1;
                x_data   = CMD_LINE1;
            end
            ADDR: if (x_done) begin
                state_nx = CHARS;
                idx_nx   = '0;
                x_start  = 1'b1;
                x_rs     = 1'b1;
                x_data   = line[0];
            end
            CHARS: if (x_done) begin
                if (idx == 4'd10) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    frame_nx = 1'b1;
                end else begin
                    idx_nx  = nidx;
                    x_start = 1'b1;
                    x_rs    = 1'b1;
                    x_data  = line[nidx];
                end
            end
            GAP: if (cnt == CW'(GAP_CLKS - 1)) begin
                state_nx = SNAP;
                cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
            default: state_nx = PWR_WAIT;
        endcase
    end

    // state registers and the per-frame input snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            idx        <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            snap       <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            init_done  <= init_nx;
            frame_done <= frame_nx;
            if (state == SNAP) snap <= {cnt_1, cnt_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10};
        end
    end
endmodule

// File: tb/tb_lcd_clock_writer.sv
// tb_lcd_clock_writer: scoreboard bench for init sequence, frame content, timing and reset abort
module tb_lcd_clock_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;

    int checks = 0, failures = 0;
    int cyc = 0, first_rise = -1, rise_cyc = 0, n_rise = 0;
    int init_cyc = -1, init_count = 0, fd_cyc = -1, fd_count = 0;
    logic e_prev = 1'b0, id_prev = 1'b0, have_fd = 1'b0;
    logic [8:0] q[$];

    lcd_clock_writer #(
        .POWERON_CLKS    (20),
        .SETUP_CLKS      (1),
        .E_CLKS          (2),
        .WAIT_CLKS       (4),
        .CLEAR_WAIT_CLKS (10),
        .GAP_CLKS        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hour_10    (hour_10),
        .hour_1     (hour_1),
        .min_10     (min_10),
        .min_1      (min_1),
        .sec_10     (sec_10),
        .sec_1      (sec_1),
        .cnt_10     (cnt_10),
        .cnt_1      (cnt_1),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // cycle index since the last reset edge
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_ch(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ? b : 8'h2D;
    endfunction

    task automatic push_init();
        q.push_back({1'b0, 8'h38});
        q.push_back({1'b0, 8'h0C});
        q.push_back({1'b0, 8'h06});
        q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_frame();
        q.push_back({1'b0, 8'h80});
        q.push_back({1'b1, exp_ch(hour_10)});
        q.push_back({1'b1, exp_ch(hour_1)});
        q.push_back({1'b1, 8'h3A});
        q.push_back({1'b1, exp_ch(min_10)});
        q.push_back({1'b1, exp_ch(min_1)});
        q.push_back({1'b1, 8'h3A});
        q.push_back({1'b1, exp_ch(sec_10)});
        q.push_back({1'b1, exp_ch(sec_1)});
        q.push_back({1'b1, 8'h2E});
        q.push_back({1'b1, exp_ch(cnt_10)});
        q.push_back({1'b1, exp_ch(cnt_1)});
    endtask

    function automatic int evcount(input int which);
        return which == 0 ? n_rise : which == 1 ? fd_count : init_count;
    endfunction

    task automatic wait_ev(input string tag, input int which, input int target);
        int n = 0;
        while (evcount(which) < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(tag, evcount(which) >= target, 1);
    endtask

    // bus monitor: pops the scoreboard on every E rise and checks pulse/frame timing
    always @(negedge clk) begin
        if (reset) begin
            e_prev     = 1'b0;
            id_prev    = 1'b0;
            have_fd    = 1'b0;
            first_rise = -1;
        end else begin
            if (lcd_e && !e_prev) begin
                n_rise++;
                rise_cyc = cyc;
                if (first_rise < 0) first_rise = cyc;
                check("rw_low", lcd_rw, 0);
                check("q_nonempty", q.size() > 0, 1);
                if (q.size() > 0) check("bus_byte", {lcd_rs, lcd_data}, q.pop_front());
            end
            if (!lcd_e && e_prev) check("e_width", cyc - rise_cyc, 2);
            if (frame_done) begin
                fd_count++;
                if (have_fd) check("fd_spacing", cyc - fd_cyc, 93);
                fd_cyc  = cyc;
                have_fd = 1'b1;
            end
            if (init_done && !id_prev) begin
                init_count++;
                init_cyc = cyc;
            end
            e_prev  = lcd_e;
            id_prev = init_done;
        end
    end

    initial begin
        hour_10 = 8'h31; hour_1 = 8'h32; min_10 = 8'h33; min_1 = 8'h34;
        sec_10  = 8'h35; sec_1  = 8'h36; cnt_10 = 8'h37; cnt_1 = 8'h38;
        push_init();
        push_frame();
        repeat (3) @(posedge clk);
        #1;
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_data", lcd_data, 0);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        wait_ev("init_seen", 2, 1);
        check("init_cyc", init_cyc, 54);
        check("first_rise", first_rise, 21);
        wait_ev("fd1_seen", 1, 1);
        check("fd1_cyc", fd_cyc, 139);
        check("q_empty_f1", q.size(), 0);
        push_frame();
        wait_ev("f2_idx3_rise", 0, 21);
        #1 sec_1 = 8'h39;
        push_frame();
        wait_ev("fd2_seen", 1, 2);
        wait_ev("f3_addr_rise", 0, 29);
        #1 hour_10 = 8'h41;
        cnt_1 = 8'h00;
        push_frame();
        wait_ev("fd4_seen", 1, 4);
        check("q_empty_f4", q.size(), 0);
        push_frame();
        wait_ev("f5_idx2_rise", 0, 56);
        #1;
        check("e_high_pre_reset", lcd_e, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_e", lcd_e, 0);
        check("abort_init_done", init_done, 0);
        check("abort_data", lcd_data, 0);
        reset = 1'b0;
        q.delete();
        push_init();
        push_frame();
        wait_ev("init2_seen", 2, 2);
        check("init2_cyc", init_cyc, 54);
        check("first_rise2", first_rise, 21);
        wait_ev("fd_after_reset", 1, 5);
        check("fd_after_reset_cyc", fd_cyc, 139);
        check("q_empty_end", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
